oh_skidbuf: RTL and testbench

OH_SKIDBUF -- requirements
Module: oh_skidbuf

---
 rtl/oh_skidbuf.sv | 118 +++++++++++
 tb/tb_oh_skidbuf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/oh_skidbuf.sv
// Two-entry skid buffer: registered output word plus a skid word, every output a flop.
// Latency 1 cycle from an accepted word into EMPTY; in_ready drops only when both entries are held.
module oh_skidbuf #(
  parameter int N   = 1,
  parameter     SYN = "TRUE"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [1:0]   level_q, level_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic [N-1:0] skid_q, skid_d;

  logic in_fire, out_fire;

  // Handshakes use only the registered readies/valids, so no in->out or out_ready->in_ready path.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d    = ST_BUSY;
          out_data_d = in_data;
        end
      end
      ST_BUSY: begin
        if (in_fire && !out_fire) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (!in_fire && out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire && out_fire) begin
          out_data_d = in_data;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d    = ST_BUSY;
          out_data_d = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    case (state_d)
      ST_BUSY: level_d = 2'd1;
      ST_FULL: level_d = 2'd2;
      default: level_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      level_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
    end
  end

  // Both branches give the same cycle behaviour; the non-TRUE form is a load-enable datapath.
  if (SYN == "TRUE") begin : g_syn
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        out_data_q <= '0;
        skid_q     <= '0;
      end else begin
        out_data_q <= out_data_d;
        skid_q     <= skid_d;
      end
    end
  end else begin : g_beh
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        out_data_q <= '0;
        skid_q     <= '0;
      end else begin
        if (out_data_d != out_data_q) out_data_q <= out_data_d;
        if (skid_d != skid_q) skid_q <= skid_d;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;

endmodule

// File: tb/tb_oh_skidbuf.sv
// Directed bench for oh_skidbuf (N = 8): reset, single word, fill/drain, stream, simultaneous, async reset, random.
module tb_oh_skidbuf;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  oh_skidbuf #(.N(8), .SYN("TRUE")) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
    in_valid = 1'b1; in_data = 8'hEE;
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_out_valid got %b want 0", out_valid); end
    in_valid = 1'b0;
    nreset = 1'b1;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    cyc();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_out_data got %h want a5", out_data); end
    n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
    in_valid = 1'b0;
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %b want 0", out_valid); end
    n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL single_drain_level got %0d want 0", level); end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    cyc();
    n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL fill1_level got %0d want 1", level); end
    in_data = 8'h22;
    cyc();
    n_checks++; if (level !== 2'd2) begin n_fail++; $display("FAIL fill2_level got %0d want 2", level); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill2_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL fill2_out_data got %h want 11", out_data); end
    // Word offered while full must be ignored.
    in_data = 8'h99;
    cyc();
    n_checks++; if (level !== 2'd2) begin n_fail++; $display("FAIL stall_level got %0d want 2", level); end
    n_checks++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL stall_out_data got %h want 11", out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    n_checks++; if (out_data !== 8'h22) begin n_fail++; $display("FAIL drain1_out_data got %h want 22", out_data); end
    n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL drain1_level got %0d want 1", level); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain1_in_ready got %b want 1", in_ready); end
    cyc();
    n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL drain2_level got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain2_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = i[7:0];
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      in_valid = 1'b1; in_data = w;
      cyc();
      n_checks++; if (out_valid !== 1'b1 || out_data !== w) begin
        n_fail++; $display("FAIL stream_word[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, w);
      end
      n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL stream_level[%0d] got %0d want 1", i, level); end
    end
    in_valid = 1'b0;
    cyc();
    n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL stream_end_level got %0d want 0", level); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    cyc();
    n_checks++; if (out_data !== 8'h55) begin n_fail++; $display("FAIL simul_first got %h want 55", out_data); end
    in_data = 8'h66; out_ready = 1'b1;
    cyc();
    n_checks++; if (out_data !== 8'h66) begin n_fail++; $display("FAIL simul_out_data got %h want 66", out_data); end
    n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL simul_level got %0d want 1", level); end
    in_valid = 1'b0;
    cyc();
    n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL simul_drain_level got %0d want 0", level); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h33;
    cyc();
    in_data = 8'h44;
    cyc();
    n_checks++; if (level !== 2'd2) begin n_fail++; $display("FAIL arst_pre_level got %0d want 2", level); end
    in_valid = 1'b0;
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL arst_level got %0d want 0", level); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL arst_out_data got %h want 00", out_data); end
    out_ready = 1'b1;
    cyc();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after_valid[%0d] got %b d=%h want 0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       iv, ordy, in_f, out_f;
    logic [7:0] d;
    int         cnt;
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = 8'($urandom_range(0, 255));
      cnt  = q.size();
      n_checks++; if (level !== 2'(cnt)) begin n_fail++; $display("FAIL rand_level[%0d] got %0d want %0d", c, level, cnt); end
      n_checks++; if (in_ready !== (cnt < 2) || out_valid !== (cnt > 0)) begin
        n_fail++; $display("FAIL rand_flags[%0d] got rdy=%b vld=%b want rdy=%b vld=%b", c, in_ready, out_valid, cnt < 2, cnt > 0);
      end
      if (cnt > 0) begin
        n_checks++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", c, out_data, q[0]); end
      end
      in_valid = iv; in_data = d; out_ready = ordy;
      in_f  = iv && (cnt < 2);
      out_f = ordy && (cnt > 0);
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(d);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL rand_final_level got %0d want 0", level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
